// File: rtl/dac_addr_seq_if.sv
// Bus between the timing trigger / control source and the DAC channel address sequencer.
// The master drives the control and window settings; the slave returns address, count and strobes.
interface dac_addr_seq_if #(
    parameter int NUM_ID = 60,
    parameter int ID_W   = 7,
    parameter int CNT_W  = 12
);
    logic              clk_enable;
    logic              trig;
    logic              abort;
    logic              mode_cont;
    logic [CNT_W-1:0]  win_start;
    logic [CNT_W-1:0]  win_end;
    logic [CNT_W-1:0]  wr_one_pos;
    logic [NUM_ID-1:0] id_mask;

    logic [ID_W-1:0]   addr;
    logic [CNT_W-1:0]  cnt;
    logic              wr;
    logic              wr_one;
    logic              mask;
    logic              busy;
    logic              done;
    logic [15:0]       frame_cnt;

    modport master (
        output clk_enable, trig, abort, mode_cont, win_start, win_end, wr_one_pos, id_mask,
        input  addr, cnt, wr, wr_one, mask, busy, done, frame_cnt
    );

    modport slave (
        input  clk_enable, trig, abort, mode_cont, win_start, win_end, wr_one_pos, id_mask,
        output addr, cnt, wr, wr_one, mask, busy, done, frame_cnt
    );
endinterface

// File: rtl/dac_addr_seq.sv
// DAC channel address sequencer: steps an ID address through NUM_ID slots of SLOT_CLKS
// enabled cycles each, generating a masked write window and a single write pulse per slot.
module dac_addr_seq #(
    parameter int NUM_ID    = 60,
    parameter int ID_W      = 7,
    parameter int SLOT_CLKS = 31,
    parameter int CNT_W     = 12
) (
    input  logic           clk,
    input  logic           reset,
    dac_addr_seq_if.slave  bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CLKS - 1);
    localparam logic [ID_W-1:0]  ADDR_LAST = ID_W'(NUM_ID - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] slot_cnt;
    logic [CNT_W-1:0] slot_cnt_next;
    logic [ID_W-1:0]  id_addr;
    logic [ID_W-1:0]  id_addr_next;
    logic             done_reg;
    logic             done_next;
    logic [15:0]      frame_count;
    logic [15:0]      frame_count_next;
    logic             busy;
    logic             mask_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            slot_cnt    <= '0;
            id_addr     <= '0;
            done_reg    <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_next;
            slot_cnt    <= slot_cnt_next;
            id_addr     <= id_addr_next;
            done_reg    <= done_next;
            frame_count <= frame_count_next;
        end
    end

    // abort beats trig, and trig beats the normal advance, so a trig on the
    // frame-end edge swallows that frame's done and frame count increment.
    always_comb begin
        state_next       = state;
        slot_cnt_next    = slot_cnt;
        id_addr_next     = id_addr;
        done_next        = 1'b0;
        frame_count_next = frame_count;

        if (bus.abort) begin
            state_next    = IDLE;
            slot_cnt_next = '0;
            id_addr_next  = '0;
        end else if (bus.trig) begin
            state_next    = RUN;
            slot_cnt_next = '0;
            id_addr_next  = '0;
        end else if (state == RUN && bus.clk_enable) begin
            if (slot_cnt < CNT_LAST) begin
                slot_cnt_next = slot_cnt + 1'b1;
            end else if (id_addr < ADDR_LAST) begin
                slot_cnt_next = '0;
                id_addr_next  = id_addr + 1'b1;
            end else begin
                slot_cnt_next    = '0;
                id_addr_next     = '0;
                done_next        = 1'b1;
                frame_count_next = frame_count + 16'd1;
                state_next       = bus.mode_cont ? RUN : IDLE;
            end
        end
    end

    // Mask lookup by explicit compare so a narrow NUM_ID never sees an oversized index.
    always_comb begin
        mask_bit = 1'b0;
        for (int i = 0; i < NUM_ID; i++) begin
            if (id_addr == ID_W'(i)) begin
                mask_bit = bus.id_mask[i];
            end
        end
    end

    assign busy = (state == RUN);

    assign bus.addr      = id_addr;
    assign bus.cnt       = slot_cnt;
    assign bus.busy      = busy;
    assign bus.done      = done_reg;
    assign bus.frame_cnt = frame_count;
    assign bus.mask      = busy & mask_bit;
    assign bus.wr        = busy & mask_bit & (slot_cnt >= bus.win_start) & (slot_cnt <= bus.win_end);
    assign bus.wr_one    = busy & (slot_cnt == bus.wr_one_pos);

endmodule
